// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit / 32-word accumulator CPU.
// Used by the controller and by memory_5x8.
package cpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/ctrl_phase_counter.sv
// Free-running phase counter with hold and synchronous load.
// Load wins over hold so a halted sequence can be restarted at a chosen phase.
module ctrl_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (!hold)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer for the accumulator CPU.
// Optional CPU_CTRL_RESUME_EN adds a resume input that restarts a halted CPU at OP_FETCH.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
`ifdef CPU_CTRL_RESUME_EN
    input  logic                    resume,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    wr,
    output logic                    ld_ir,
    output logic                    data_e,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    ld_ac,
    output logic                    halt,
    output logic [PHASE_WIDTH-1:0]  phase
);

    opcode_t op;
    phase_t  ph;
    logic    halted;
    logic    halt_set;
    logic    resume_go;
    logic    aluop;

    assign op    = opcode_t'(opcode);
    assign ph    = phase_t'(phase);
    assign aluop = is_aluop(op);

    // The halting edge itself must not advance the phase, so hold covers it too.
    assign halt_set = !halted && (ph == OP_ADDR) && (op == HLT);

`ifdef CPU_CTRL_RESUME_EN
    assign resume_go = halted && resume;
`else
    assign resume_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            halted <= 1'b0;
        else if (halt_set)
            halted <= 1'b1;
        else if (resume_go)
            halted <= 1'b0;
    end

    ctrl_phase_counter #(
        .WIDTH(PHASE_WIDTH)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .hold     (halted | halt_set),
        .load     (resume_go),
        .load_val (PHASE_WIDTH'(OP_FETCH)),
        .count    (phase)
    );

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        data_e = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        halt   = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (ph)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == HLT);
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == JMP);
                    wr     = (op == STO);
                    data_e = (op == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed literal checks, then random opcodes/zero/resets
// compared every cycle against a phase/halt model derived from the instruction-cycle rules.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
`ifdef CPU_CTRL_RESUME_EN
    logic       resume = 1'b0;
`endif
    logic       sel, rd, wr, ld_ir, data_e, inc_pc, ld_pc, ld_ac, halt;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef CPU_CTRL_RESUME_EN
        .resume (resume),
`endif
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .data_e (data_e),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .halt   (halt),
        .phase  (phase)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: where in the instruction cycle we are, and whether halted.
    int m_phase  = 0;
    bit m_halted = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase  <= 0;
            m_halted <= 0;
        end else if (m_halted) begin
`ifdef CPU_CTRL_RESUME_EN
            if (resume) begin
                m_halted <= 0;
                m_phase  <= 5;
            end
`endif
        end else if (m_phase == 4 && opcode == 3'd0) begin
            m_halted <= 1;
        end else begin
            m_phase <= (m_phase + 1) % 8;
        end
    end

    // Expected {sel,rd,wr,ld_ir,data_e,inc_pc,ld_pc,ld_ac,halt,phase}.
    function automatic logic [11:0] model_out(int ph, int op, bit z, bit h);
        bit alu, s, r, w, li, de, ip, lp, la, hl;
        if (h) return {9'b0000_0000_1, 3'd4};
        alu = (op >= 2 && op <= 5);
        s  = (ph <= 3);
        r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        w  = (ph == 7) && (op == 6);
        li = (ph == 2) || (ph == 3);
        de = (ph >= 6) && (op == 6);
        ip = (ph == 4) || (ph == 6 && op == 1 && z);
        lp = (ph >= 6) && (op == 7);
        la = (ph == 7) && alu;
        hl = (ph == 4) && (op == 0);
        return {s, r, w, li, de, ip, lp, la, hl, 3'(ph)};
    endfunction

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle", {20'd0, sel, rd, wr, ld_ir, data_e, inc_pc, ld_pc, ld_ac, halt, phase},
                {20'd0, model_out(m_phase, int'(opcode), zero, m_halted)});
            chk("bus_rd_data_e", {31'd0, rd & data_e}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd1);
        chk("rst_others", {24'd0, rd, wr, ld_ir, data_e, inc_pc, ld_pc, ld_ac, halt}, 32'd0);
        cmp_en = 1;
        step(1);
        rst = 1'b1;
        step(1);
        #1 chk("release_phase1", {29'd0, phase}, 32'd1);

        // ADD at phase 7: read operand and load accumulator
        step(6);
        #1 chk("add_p7_rd_ldac_wr", {29'd0, rd, ld_ac, wr}, 32'b110);

        // STO at phase 7: write, drive bus, no read
        step(1);
        opcode = 3'd6;
        step(7);
        #1 chk("sto_p7_wr_de_rd", {29'd0, wr, data_e, rd}, 32'b110);

        // HLT: halt+inc_pc in phase 4, then frozen
        step(1);
        opcode = 3'd0;
        step(4);
        #1 chk("hlt_p4_halt_inc", {30'd0, halt, inc_pc}, 32'b11);
        step(3);
        #1 chk("halted_phase", {29'd0, phase}, 32'd4);
        chk("halted_strobes", {23'd0, sel, rd, wr, ld_ir, data_e, inc_pc, ld_pc, ld_ac, halt}, 32'd1);
`ifdef CPU_CTRL_RESUME_EN
        resume = 1'b1;
        step(1);
        resume = 1'b0;
        #1 chk("resume_phase_halt", {28'd0, phase, halt}, {28'd0, 3'd5, 1'b0});
`endif

        // Reset mid-instruction at phase 6
        rst = 1'b0;
        opcode = 3'd2;
        step(1);
        rst = 1'b1;
        step(6);
        #1 chk("pre_rst_phase6", {29'd0, phase}, 32'd6);
        rst = 1'b0;
        #1 chk("mid_rst_phase0", {29'd0, phase}, 32'd0);
        chk("mid_rst_sel", {31'd0, sel}, 32'd1);
        step(1);
        rst = 1'b1;
        step(1);
        #1 chk("mid_rst_release", {29'd0, phase}, 32'd1);

        // Random run
        for (int i = 0; i < 3000; i++) begin
            step(1);
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
`ifdef CPU_CTRL_RESUME_EN
            resume = ($urandom_range(0, 5) == 0);
            rst    = !(m_halted && $urandom_range(0, 40) == 0) && ($urandom_range(0, 60) != 0);
`else
            rst    = !(m_halted && $urandom_range(0, 6) == 0) && ($urandom_range(0, 60) != 0);
`endif
        end
        step(1);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
